// File: rtl/algorithm_ctrl_nch.sv
// ============================================================================
//  Module      : algorithm_ctrl_nch
//  Description : NCH-channel command sequencer with a command FIFO, optional
//                NN request (absolute/offset), height-to-time ROM lookup and
//                a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module algorithm_ctrl_nch #(
    parameter int NCH        = 3,
    parameter int DW         = 16,
    parameter int AW         = 11,
    parameter int SHIFT      = 2,
    parameter int ROM_LAT    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_CYC   = 2048,
    parameter int NN_TMO     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_in_vld,
    output logic              o_cmd_in_rdy,
    input  logic [3:0]        i_cmd_in_type,
    input  logic [3:0]        i_cmd_in_range,
    input  logic [DW-1:0]     i_cmd_in_time,
    input  logic [NCH*DW-1:0] i_cmd_in_data,
    output logic              o_nnp_req,
    input  logic              i_nnp_ack,
    output logic [3:0]        o_nnp_type,
    output logic [NCH*DW-1:0] o_nnp_data_out,
    input  logic              i_nnp_vld,
    input  logic [NCH*DW-1:0] i_nnp_data_in,
    output logic [AW-1:0]     o_rom_addr,
    input  logic [DW-1:0]     i_rom_data,
    output logic              o_cmd_out_vld,
    input  logic              i_cmd_out_rdy,
    output logic [3:0]        o_cmd_out_range,
    output logic [DW-1:0]     o_cmd_out_time,
    output logic [NCH*DW-1:0] o_cmd_out_data,
    output logic              o_err_tmo,
    output logic [7:0]        o_drop_cnt
);

    localparam int c_FW      = 8 + DW + NCH*DW;
    localparam int c_PW      = $clog2(FIFO_DEPTH);
    localparam int c_M1      = (IDLE_CYC > NN_TMO) ? IDLE_CYC : NN_TMO;
    localparam int c_CNT_MAX = (c_M1 > ROM_LAT + NCH) ? c_M1 : ROM_LAT + NCH;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_REQ    = 3'd3;
    localparam logic [2:0] c_WAIT   = 3'd4;
    localparam logic [2:0] c_LOOKUP = 3'd5;
    localparam logic [2:0] c_OUTPUT = 3'd6;

    // Negative heights clamp to 0, oversize heights clamp to the top entry.
    function automatic logic [AW-1:0] f_map(input logic [DW-1:0] h);
        logic [DW-1:0] sh;
        sh = h >> SHIFT;
        if (h[DW-1])
            f_map = '0;
        else if ((sh >> AW) != '0)
            f_map = '1;
        else
            f_map = sh[AW-1:0];
    endfunction

    logic [c_FW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PW:0]     r_wr_ptr, r_rd_ptr;
    logic [c_FW-1:0]   r_rd_data;
    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [3:0]        r_type, r_range;
    logic [DW-1:0]     r_time;
    logic [NCH*DW-1:0] r_data, r_h, r_out;
    logic [AW-1:0]     r_addr;
    logic              r_err;
    logic [7:0]        r_drop;

    logic              w_full, w_empty, w_wr, w_rd;
    logic [3:0]        w_f_type;
    logic [NCH*DW-1:0] w_f_data, w_h_nn;
    logic [DW-1:0]     w_h_sel;

    assign w_full   = (r_wr_ptr - r_rd_ptr) == (c_PW+1)'(FIFO_DEPTH);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_wr     = i_cmd_in_vld && !w_full;
    assign w_rd     = (r_state == c_FETCH) && !w_empty;
    assign w_f_type = r_rd_data[c_FW-1 -: 4];
    assign w_f_data = r_rd_data[NCH*DW-1:0];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[c_PW-1:0]] <= {i_cmd_in_type, i_cmd_in_range, i_cmd_in_time, i_cmd_in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + (c_PW+1)'(1);
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + (c_PW+1)'(1);
                r_rd_data <= r_mem[r_rd_ptr[c_PW-1:0]];
            end
        end
    end

    always_comb begin
        w_h_nn  = '0;
        w_h_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_type == 4'd2)
                w_h_nn[i*DW +: DW] = r_data[i*DW +: DW] + i_nnp_data_in[i*DW +: DW];
            else
                w_h_nn[i*DW +: DW] = i_nnp_data_in[i*DW +: DW];
            if (r_cnt == c_CW'(i))
                w_h_sel = r_h[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_type  <= '0;
            r_range <= '0;
            r_time  <= '0;
            r_data  <= '0;
            r_h     <= '0;
            r_out   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_err  <= 1'b0;
            r_addr <= '0;
            case (r_state)
                c_IDLE: begin
                    if (r_cnt == c_CW'(IDLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= c_FETCH;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_FETCH: begin
                    if (!w_empty)
                        r_state <= c_DECODE;
                end
                c_DECODE: begin
                    r_type  <= w_f_type;
                    r_range <= r_rd_data[c_FW-5 -: 4];
                    r_time  <= r_rd_data[NCH*DW +: DW];
                    r_data  <= w_f_data;
                    r_cnt   <= '0;
                    case (w_f_type)
                        4'd0: begin
                            r_h     <= w_f_data;
                            r_state <= c_LOOKUP;
                        end
                        4'd1, 4'd2: r_state <= c_REQ;
                        default: begin
                            if (r_drop != 8'hFF)
                                r_drop <= r_drop + 8'd1;
                            r_state <= c_FETCH;
                        end
                    endcase
                end
                // The same counter times the NN from the first nnp_req cycle.
                c_REQ, c_WAIT: begin
                    if (i_nnp_vld) begin
                        r_h     <= w_h_nn;
                        r_cnt   <= '0;
                        r_state <= c_LOOKUP;
                    end else if (r_cnt == c_CW'(NN_TMO - 1)) begin
                        r_err <= 1'b1;
                        if (r_drop != 8'hFF)
                            r_drop <= r_drop + 8'd1;
                        r_state <= c_FETCH;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_state == c_REQ && i_nnp_ack)
                            r_state <= c_WAIT;
                    end
                end
                c_LOOKUP: begin
                    if (r_cnt < c_CW'(NCH))
                        r_addr <= f_map(w_h_sel);
                    for (int i = 0; i < NCH; i++) begin
                        if (r_cnt == c_CW'(ROM_LAT + 1 + i))
                            r_out[i*DW +: DW] <= i_rom_data;
                    end
                    if (r_cnt == c_CW'(ROM_LAT + NCH))
                        r_state <= c_OUTPUT;
                    else
                        r_cnt <= r_cnt + c_CW'(1);
                end
                c_OUTPUT: begin
                    if (i_cmd_out_rdy)
                        r_state <= c_FETCH;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_cmd_in_rdy    = !w_full;
    assign o_nnp_req       = (r_state == c_REQ);
    assign o_nnp_type      = o_nnp_req ? r_type : 4'd0;
    assign o_nnp_data_out  = o_nnp_req ? r_data : '0;
    assign o_rom_addr      = r_addr;
    assign o_cmd_out_vld   = (r_state == c_OUTPUT);
    assign o_cmd_out_range = r_range;
    assign o_cmd_out_time  = r_time;
    assign o_cmd_out_data  = r_out;
    assign o_err_tmo       = r_err;
    assign o_drop_cnt      = r_drop;

endmodule

`default_nettype wire
